mac_array_acc: RTL and testbench
================================

MAC_ARRAY_ACC -- requirements
Module: mac_array_acc

Interface
REQ-001 Parameter DW, default 8, signed activation/weight width.
REQ-002 Parameter CW, default 19, signed partial-sum width inside the array.
REQ-003 Parameter OW, default 26, signed accumulator/output width; OW >= CW.
REQ-004 Parameter ROW, default 7, array rows (any value >= 1).
REQ-005 Parameter COLUMN, default 7, array columns (any value >= 1).
REQ-006 Port clk, input, 1, single clock; all state on rising edge.
REQ-007 Port rst_n, input, 1, asynchronous active-low reset.
REQ-008 Port w, input, COLUMN*DW, weight vector; column c at [c*DW +: DW].
REQ-009 Port w_en, input, ROW, per-row weight load strobe.
REQ-010 Port in_valid, input, 1, x/ci sample valid.
REQ-011 Port in_first, input, 1, first sample of an accumulation window; qualified by in_valid.
REQ-012 Port in_last, input, 1, last sample of a window; qualified by in_valid.
REQ-013 Port x, input, ROW*DW, activation per row; row r at [r*DW +: DW].
REQ-014 Port ci, input, COLUMN*CW, partial-sum injection into row 0.
REQ-015 Port out_valid, output, 1, one-cycle pulse: out_data holds a finished window.
REQ-016 Port out_data, output, COLUMN*OW, accumulated result per column.
REQ-017 Port out_sat, output, COLUMN, per-column saturation flag for the emitted window.

Function
REQ-018 Each cell (r,c) SHALL hold a DW-bit weight register, loaded from w[c] on an edge where w_en[r]=1.
REQ-019 Input skew SHALL be internal: x row r SHALL be delayed r cycles before reaching row r, so all rows of one sample meet the same partial sum.
REQ-020 Row r SHALL register psum_r[c] = psum_(r-1)[c] + x_r*w_r[c] (psum_(-1)=ci). Arithmetic is signed, wraps modulo 2^CW.
REQ-021 A weight load SHALL affect only samples whose skewed x reaches that row on a later edge.
REQ-022 in_valid/in_first/in_last SHALL travel a ROW-stage shift register aligned with the partial sums.
REQ-023 Accumulator FSM states: IDLE, ACC.
REQ-024 On an aligned valid sample with first=1, or any valid sample in IDLE: acc = sign-extend(psum) and sat flags clear; state -> ACC.
REQ-025 In ACC, a valid sample without first: acc = acc + sign-extend(psum), saturating to [-2^(OW-1), 2^(OW-1)-1]; set out_sat[c] (sticky) when column c clips.
REQ-026 A valid sample with last=1 (including first&last together) SHALL pulse out_valid with the post-update acc and flags on the next cycle, then go to IDLE.
REQ-027 first arriving in ACC SHALL silently discard the open window and restart; no out_valid.
REQ-028 Latency: sample with in_last at edge t -> out_valid high in cycle t+ROW+1.
REQ-029 Invalid cycles (in_valid=0) SHALL leave acc, flags and state unchanged; gaps inside a window are legal.
REQ-030 out_data/out_sat SHALL hold their last value between pulses.
REQ-031 Back-to-back windows (last then first on the next cycle) SHALL be processed at full rate.

Reset
REQ-032 rst_n low SHALL clear weights, skew and psum registers, control pipeline, acc, out_data, out_sat and out_valid to 0, and set state IDLE.
REQ-033 Reset mid-window SHALL discard the window; no out_valid until a new last is seen after release.

Structure
REQ-034 Package mac_pkg SHALL hold the default DW/CW/OW/ROW/COLUMN constants and the IDLE/ACC state encoding.
REQ-035 Sub-module mac_cell (weight register, multiply, add, psum register) SHALL be instantiated ROW*COLUMN times by generate loops.

Verification
REQ-036 ROW=COLUMN=7, all weights 1, x all 2, ci 0, single sample first&last -> out_valid at t+8, every column 14, out_sat 0.
REQ-037 Weights w[c]=c+1, x all 1, window of 3 samples -> each column 3*7*(c+1), single out_valid.
REQ-038 OW=20, weights 127, x 127, CW=19 psums, windows of 20 samples -> output 2^19-1, out_sat all 1.
REQ-039 first reissued mid-window after 2 samples, then 1 sample with last -> result counts only the restarted window.
REQ-040 rst_n pulsed low for 1 cycle mid-window -> no out_valid; all outputs 0 while reset is held low.
REQ-041 w_en[3] toggled with new weights during streaming -> the per-sample golden model, with the weight change applied at row 3 only, matches all outputs.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg: default array geometry/widths and the accumulator state encoding
// shared by the MAC array and its cells.
package mac_pkg;
    localparam int DW_DEF  = 8;
    localparam int CW_DEF  = 19;
    localparam int OW_DEF  = 26;
    localparam int ROW_DEF = 7;
    localparam int COL_DEF = 7;

    typedef enum logic {IDLE = 1'b0, ACC = 1'b1} acc_state_t;
endpackage

// File: rtl/mac_cell.sv
// mac_cell: one array cell; holds a weight, multiplies the skewed activation
// and adds it to the incoming partial sum, registering the result.
module mac_cell import mac_pkg::*; #(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_w_en,
    input  logic [DW-1:0] i_w,
    input  logic [DW-1:0] i_x,
    input  logic [CW-1:0] i_psum,
    output logic [CW-1:0] o_psum
);
    logic        [DW-1:0] r_w;
    logic        [CW-1:0] r_psum;
    logic signed [CW-1:0] w_xe, w_we;

    // product is only needed modulo 2^CW, so multiply at CW bits
    assign w_xe   = CW'($signed(i_x));
    assign w_we   = CW'($signed(r_w));
    assign o_psum = r_psum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w    <= '0;
            r_psum <= '0;
        end else begin
            if (i_w_en) r_w <= i_w;
            r_psum <= i_psum + (w_xe * w_we);
        end
    end
endmodule

// File: rtl/mac_array_acc.sv
// mac_array_acc: ROW x COLUMN weight-stationary MAC array with internal input
// skew and a saturating per-column window accumulator.
module mac_array_acc import mac_pkg::*; #(
    parameter int DW     = DW_DEF,
    parameter int CW     = CW_DEF,
    parameter int OW     = OW_DEF,
    parameter int ROW    = ROW_DEF,
    parameter int COLUMN = COL_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [COLUMN*DW-1:0] w,
    input  logic [ROW-1:0]       w_en,
    input  logic                 in_valid,
    input  logic                 in_first,
    input  logic                 in_last,
    input  logic [ROW*DW-1:0]    x,
    input  logic [COLUMN*CW-1:0] ci,
    output logic                 out_valid,
    output logic [COLUMN*OW-1:0] out_data,
    output logic [COLUMN-1:0]    out_sat
);
    logic [DW-1:0]        w_xs [ROW];
    logic [CW-1:0]        w_ps [ROW+1][COLUMN];
    logic [ROW-1:0]       r_vld, r_fst, r_lst;
    logic                 w_v, w_f, w_l, w_restart, w_emit;
    acc_state_t           r_st, w_st_n;
    logic signed [OW-1:0] r_acc   [COLUMN];
    logic signed [OW-1:0] w_acc_n [COLUMN];
    logic [COLUMN-1:0]    r_sat, w_sat_n;

    genvar r, c;
    for (r = 0; r < ROW; r++) begin : g_row
        if (r == 0) begin : g_nd
            assign w_xs[r] = x[0 +: DW];
        end else begin : g_sk
            // row r sees its activation r cycles late so it meets the right psum
            logic [r*DW-1:0] r_sk;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_sk <= '0;
                else        r_sk <= (r*DW)'({r_sk, x[r*DW +: DW]});
            end
            assign w_xs[r] = r_sk[r*DW-1 -: DW];
        end
        for (c = 0; c < COLUMN; c++) begin : g_cell
            mac_cell #(.DW(DW), .CW(CW)) u_cell (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_w_en (w_en[r]),
                .i_w    (w[c*DW +: DW]),
                .i_x    (w_xs[r]),
                .i_psum (w_ps[r][c]),
                .o_psum (w_ps[r+1][c])
            );
        end
    end

    for (c = 0; c < COLUMN; c++) begin : g_ci
        assign w_ps[0][c] = ci[c*CW +: CW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_fst <= '0;
            r_lst <= '0;
        end else begin
            r_vld <= ROW'({r_vld, in_valid});
            r_fst <= ROW'({r_fst, in_first});
            r_lst <= ROW'({r_lst, in_last});
        end
    end

    assign w_v = r_vld[ROW-1];
    assign w_f = r_fst[ROW-1];
    assign w_l = r_lst[ROW-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_st <= IDLE;
        else        r_st <= w_st_n;
    end

    always_comb w_st_n = !w_v ? r_st : (w_l ? IDLE : ACC);

    always_comb begin
        w_restart = w_v & (w_f | (r_st == IDLE));
        w_emit    = w_v & w_l;
    end

    for (c = 0; c < COLUMN; c++) begin : g_col
        logic signed [OW-1:0] w_ext;
        logic signed [OW:0]   w_sum;
        logic                 w_clip;
        assign w_ext        = OW'($signed(w_ps[ROW][c]));
        assign w_sum        = (OW+1)'(r_acc[c]) + (OW+1)'(w_ext);
        assign w_clip       = w_sum[OW] ^ w_sum[OW-1];
        assign w_acc_n[c]   = !w_v ? r_acc[c] : w_restart ? w_ext :
                              w_clip ? {w_sum[OW], {(OW-1){~w_sum[OW]}}} : w_sum[OW-1:0];
        assign w_sat_n[c]   = !w_v ? r_sat[c] : (!w_restart & (r_sat[c] | w_clip));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < COLUMN; i++) r_acc[i] <= '0;
            r_sat     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= '0;
        end else begin
            for (int i = 0; i < COLUMN; i++) r_acc[i] <= w_acc_n[i];
            r_sat     <= w_sat_n;
            out_valid <= w_emit;
            if (w_emit) begin
                for (int i = 0; i < COLUMN; i++) out_data[i*OW +: OW] <= w_acc_n[i];
                out_sat <= w_sat_n;
            end
        end
    end
endmodule

// File: tb/tb_mac_array_acc.sv
// tb_mac_array_acc: scoreboard bench for the MAC array accumulator, driving a
// default-width instance and an OW=20 instance from the same stimulus.
module tb_mac_array_acc;
    localparam int ROW = 7;
    localparam int COL = 7;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [55:0]  w = '0;
    logic [6:0]   w_en = '0;
    logic         in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
    logic [55:0]  x = '0;
    logic [132:0] ci = '0;
    logic         d_valid, s_valid;
    logic [181:0] d_data;
    logic [139:0] s_data;
    logic [6:0]   d_sat, s_sat;

    mac_array_acc u_dut (
        .clk(clk), .rst_n(rst_n), .w(w), .w_en(w_en), .in_valid(in_valid),
        .in_first(in_first), .in_last(in_last), .x(x), .ci(ci),
        .out_valid(d_valid), .out_data(d_data), .out_sat(d_sat)
    );

    mac_array_acc #(.OW(20)) u_sat (
        .clk(clk), .rst_n(rst_n), .w(w), .w_en(w_en), .in_valid(in_valid),
        .in_first(in_first), .in_last(in_last), .x(x), .ci(ci),
        .out_valid(s_valid), .out_data(s_data), .out_sat(s_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                 t;
        bit                 f;
        bit                 l;
        logic signed [7:0]  xs [7];
        logic signed [18:0] cs [7];
    } samp_t;

    typedef struct {
        int     cyc;
        longint d [7];
        bit     s [7];
    } res_t;

    logic signed [7:0]  xv [7];
    logic signed [7:0]  wv [7];
    logic signed [18:0] cv [7];
    logic signed [7:0]  mw [7][7];
    logic signed [7:0]  wh [4096][7][7];
    samp_t  pend [$];
    res_t   expq [2][$];
    longint macc [2][7];
    bit     msat [2][7];
    bit     mst = 1'b0;
    int     ows [2] = '{26, 20};
    int     cyc = 0, n_cmp = 0, n_bad = 0, n_pulse = 0;

    // transaction model: a sample's psum uses, for row r, the weights that were
    // registered before the edge where its skewed activation reaches row r
    function automatic void process(input samp_t s);
        longint ps [7];
        longint a, mx;
        res_t   e;
        for (int c = 0; c < COL; c++) begin
            ps[c] = longint'(s.cs[c]);
            for (int r = 0; r < ROW; r++)
                ps[c] += longint'(s.xs[r]) * longint'(wh[s.t + r - 1][r][c]);
            ps[c] = (ps[c] <<< 45) >>> 45;
        end
        for (int k = 0; k < 2; k++) begin
            mx = (longint'(1) <<< (ows[k] - 1)) - 1;
            for (int c = 0; c < COL; c++) begin
                if (s.f || !mst) begin
                    macc[k][c] = ps[c];
                    msat[k][c] = 1'b0;
                end else begin
                    a = macc[k][c] + ps[c];
                    if (a > mx) begin a = mx; msat[k][c] = 1'b1; end
                    if (a < -mx - 1) begin a = -mx - 1; msat[k][c] = 1'b1; end
                    macc[k][c] = a;
                end
            end
            if (s.l) begin
                e.cyc = s.t + ROW;
                for (int c = 0; c < COL; c++) begin
                    e.d[c] = macc[k][c];
                    e.s[c] = msat[k][c];
                end
                expq[k].push_back(e);
            end
        end
        mst = !s.l;
    endfunction

    task automatic step(input bit v, input bit f, input bit l, input logic [6:0] we);
        samp_t s;
        in_valid = v; in_first = f; in_last = l; w_en = we;
        for (int i = 0; i < 7; i++) begin
            w[i*8 +: 8]   = wv[i];
            x[i*8 +: 8]   = xv[i];
            ci[i*19 +: 19] = cv[i];
        end
        @(posedge clk);
        cyc++;
        if (rst_n) begin
            for (int r = 0; r < ROW; r++)
                if (we[r]) for (int c = 0; c < COL; c++) mw[r][c] = wv[c];
            if (v) begin
                s.t = cyc; s.f = f; s.l = l;
                for (int i = 0; i < 7; i++) begin s.xs[i] = xv[i]; s.cs[i] = cv[i]; end
                pend.push_back(s);
            end
        end
        for (int r = 0; r < ROW; r++) for (int c = 0; c < COL; c++) wh[cyc][r][c] = mw[r][c];
        while (pend.size() > 0 && pend[0].t + ROW - 1 <= cyc) process(pend.pop_front());
        #1;
        in_valid = 1'b0; w_en = '0;
    endtask

    task automatic flush(input int n);
        repeat (n) step(0, 0, 0, '0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        mst = 1'b0;
        pend.delete();
        for (int r = 0; r < ROW; r++) for (int c = 0; c < COL; c++) begin
            mw[r][c] = '0;
            wh[cyc][r][c] = '0;
        end
        for (int k = 0; k < 2; k++)
            while (expq[k].size() > 0 && expq[k][$].cyc > cyc) void'(expq[k].pop_back());
    endtask

    task automatic check_zero_outputs(input string tag);
        n_cmp++; if (d_valid !== 1'b0) begin n_bad++; $display("FAIL %s_valid got %b want 0", tag, d_valid); end
        n_cmp++; if (d_data !== '0) begin n_bad++; $display("FAIL %s_data got %h want 0", tag, d_data); end
        n_cmp++; if (d_sat !== '0) begin n_bad++; $display("FAIL %s_sat got %b want 0", tag, d_sat); end
        n_cmp++; if (s_valid !== 1'b0) begin n_bad++; $display("FAIL %s_valid20 got %b want 0", tag, s_valid); end
        n_cmp++; if (s_data !== '0) begin n_bad++; $display("FAIL %s_data20 got %h want 0", tag, s_data); end
        n_cmp++; if (s_sat !== '0) begin n_bad++; $display("FAIL %s_sat20 got %b want 0", tag, s_sat); end
    endtask

    res_t   mon_e;
    longint mon_od, mon_got;
    int     mon_bc;
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (k == 0 ? d_valid : s_valid) begin
                if (k == 0) n_pulse++;
                n_cmp++;
                if (expq[k].size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_out_valid dut%0d at cycle %0d", k, cyc);
                end else begin
                    mon_e = expq[k].pop_front();
                    if (cyc !== mon_e.cyc) begin
                        n_bad++;
                        $display("FAIL latency dut%0d out_valid at cycle %0d want %0d", k, cyc, mon_e.cyc);
                    end
                    mon_bc = -1;
                    mon_got = 0;
                    for (int c = 0; c < COL; c++) begin
                        mon_od = (k == 1) ? longint'($signed(s_data[c*20 +: 20])) : longint'($signed(d_data[c*26 +: 26]));
                        if (mon_bc < 0 && mon_od !== mon_e.d[c]) begin mon_bc = c; mon_got = mon_od; end
                    end
                    n_cmp++;
                    if (mon_bc >= 0) begin
                        n_bad++;
                        $display("FAIL result dut%0d cycle %0d col %0d got %0d want %0d", k, cyc, mon_bc, mon_got, mon_e.d[mon_bc]);
                    end
                    for (int c = 0; c < COL; c++) begin
                        n_cmp++;
                        if (((k == 1) ? s_sat[c] : d_sat[c]) !== mon_e.s[c]) begin
                            n_bad++;
                            $display("FAIL sat dut%0d cycle %0d col %0d got %b want %b", k, cyc, c, (k == 1) ? s_sat[c] : d_sat[c], mon_e.s[c]);
                        end
                    end
                end
            end
        end
    end

    task automatic test_reset();
        for (int i = 0; i < 7; i++) begin xv[i] = 8'sd5; wv[i] = 8'sd3; cv[i] = 19'sd9; end
        apply_reset();
        step(1, 1, 1, 7'h7f);
        step(1, 1, 1, 7'h7f);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        flush(ROW + 2);
        check_zero_outputs("after_reset");
    endtask

    task automatic test_ones();
        int p0;
        for (int i = 0; i < 7; i++) begin wv[i] = 8'sd1; xv[i] = 8'sd2; cv[i] = '0; end
        step(0, 0, 0, 7'h7f);
        p0 = n_pulse;
        step(1, 1, 1, '0);
        flush(ROW + 2);
        n_cmp++; if (n_pulse !== p0 + 1) begin n_bad++; $display("FAIL ones_pulses got %0d want %0d", n_pulse - p0, 1); end
        for (int c = 0; c < COL; c++) begin
            n_cmp++;
            if ($signed(d_data[c*26 +: 26]) !== 26'sd14) begin n_bad++; $display("FAIL ones_col%0d got %0d want 14", c, $signed(d_data[c*26 +: 26])); end
        end
        n_cmp++; if (d_sat !== 7'h00) begin n_bad++; $display("FAIL ones_sat got %b want 0", d_sat); end
    endtask

    task automatic test_window3();
        int p0;
        for (int i = 0; i < 7; i++) begin wv[i] = 8'(i + 1); xv[i] = 8'sd1; end
        step(0, 0, 0, 7'h7f);
        p0 = n_pulse;
        step(1, 1, 0, '0);
        step(1, 0, 0, '0);
        step(1, 0, 1, '0);
        flush(ROW + 5);
        n_cmp++; if (n_pulse !== p0 + 1) begin n_bad++; $display("FAIL win3_pulses got %0d want 1", n_pulse - p0); end
        for (int c = 0; c < COL; c++) begin
            n_cmp++;
            if ($signed(d_data[c*26 +: 26]) !== 26'(21 * (c + 1))) begin
                n_bad++; $display("FAIL win3_hold_col%0d got %0d want %0d", c, $signed(d_data[c*26 +: 26]), 21 * (c + 1));
            end
        end
    endtask

    task automatic test_saturation();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 7; i++) begin wv[i] = pass ? -8'sd128 : 8'sd127; xv[i] = 8'sd127; cv[i] = '0; end
            step(0, 0, 0, 7'h7f);
            for (int i = 0; i < 20; i++) step(1, i == 0, i == 19, '0);
            flush(ROW + 2);
            for (int c = 0; c < COL; c++) begin
                n_cmp++;
                if ($signed(s_data[c*20 +: 20]) !== (pass ? -20'sd524288 : 20'sd524287)) begin
                    n_bad++; $display("FAIL sat%0d_col%0d got %0d want %0d", pass, c, $signed(s_data[c*20 +: 20]), pass ? -524288 : 524287);
                end
            end
            n_cmp++; if (s_sat !== 7'h7f) begin n_bad++; $display("FAIL sat%0d_flags got %b want 1111111", pass, s_sat); end
            n_cmp++; if (d_sat !== 7'h00) begin n_bad++; $display("FAIL sat%0d_wide_flags got %b want 0", pass, d_sat); end
        end
    endtask

    task automatic test_restart();
        int     p0;
        longint ex;
        for (int i = 0; i < 7; i++) begin wv[i] = 8'($urandom); cv[i] = '0; end
        step(0, 0, 0, 7'h7f);
        p0 = n_pulse;
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 7; i++) xv[i] = 8'($urandom);
            step(1, 1, s == 2, '0);
        end
        flush(ROW + 2);
        n_cmp++; if (n_pulse !== p0 + 1) begin n_bad++; $display("FAIL restart_pulses got %0d want 1", n_pulse - p0); end
        for (int c = 0; c < COL; c++) begin
            ex = 0;
            for (int r = 0; r < ROW; r++) ex += longint'(xv[r]) * longint'(wv[c]);
            n_cmp++;
            if (longint'($signed(d_data[c*26 +: 26])) !== ex) begin
                n_bad++; $display("FAIL restart_col%0d got %0d want %0d", c, $signed(d_data[c*26 +: 26]), ex);
            end
        end
    endtask

    task automatic test_reset_mid();
        int p0;
        step(1, 1, 0, '0);
        step(1, 0, 0, '0);
        p0 = n_pulse;
        apply_reset();
        #1;
        check_zero_outputs("midreset");
        step(0, 0, 0, '0);
        rst_n = 1'b1;
        flush(ROW + 3);
        n_cmp++; if (n_pulse !== p0) begin n_bad++; $display("FAIL midreset_pulses got %0d want 0", n_pulse - p0); end
        for (int i = 0; i < 7; i++) begin wv[i] = 8'sd1; xv[i] = 8'sd1; cv[i] = '0; end
        step(0, 0, 0, 7'h7f);
        step(1, 0, 1, '0);
        flush(ROW + 2);
        n_cmp++; if (n_pulse !== p0 + 1) begin n_bad++; $display("FAIL postreset_pulses got %0d want 1", n_pulse - p0); end
        n_cmp++; if ($signed(d_data[0 +: 26]) !== 26'sd7) begin n_bad++; $display("FAIL postreset_col0 got %0d want 7", $signed(d_data[0 +: 26])); end
    endtask

    task automatic test_stream();
        int p0, n_last;
        bit open, v, f, l;
        for (int i = 0; i < 7; i++) wv[i] = 8'($urandom);
        step(0, 0, 0, 7'h7f);
        p0 = n_pulse; n_last = 0; open = 1'b0;
        for (int i = 0; i < 60; i++) begin
            for (int j = 0; j < 7; j++) begin xv[j] = 8'($urandom); cv[j] = 19'($urandom); end
            v = $urandom_range(0, 4) != 0;
            f = !open || $urandom_range(0, 9) == 0;
            l = $urandom_range(0, 2) == 0;
            if (i == 20 || i == 41) for (int j = 0; j < 7; j++) wv[j] = 8'($urandom);
            step(v, f, l, (i == 20 || i == 41) ? 7'b0001000 : 7'b0);
            if (v) begin open = !l; n_last += l; end
        end
        flush(ROW + 2);
        n_cmp++; if (n_pulse !== p0 + n_last) begin n_bad++; $display("FAIL stream_pulses got %0d want %0d", n_pulse - p0, n_last); end
    endtask

    task automatic test_drain();
        flush(ROW + 3);
        n_cmp++; if (expq[0].size() !== 0) begin n_bad++; $display("FAIL drain_missing got %0d pending want 0", expq[0].size()); end
        n_cmp++; if (expq[1].size() !== 0) begin n_bad++; $display("FAIL drain_missing20 got %0d pending want 0", expq[1].size()); end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_window3();
        test_saturation();
        test_restart();
        test_reset_mid();
        test_stream();
        test_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
